// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state encoding and
// the owner codes used when selecting which requester drives the memory.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_RESP_I = 3'd3,
    ARB_RESP_D = 3'd4
  } arb_state_t;

  typedef logic arb_owner_t;

  localparam arb_owner_t OWN_IF = 1'b0;
  localparam arb_owner_t OWN_DM = 1'b1;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Saturating count of contested data grants; at_max tells the arbiter to hand
// the next contested slot to instruction fetch. Only built with ARB_FAIR_EN.
module mem_arb_streak_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != W'(MAX))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_max = (count_reg == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and data requests onto one single-ported memory, one
// transaction at a time. Define ARB_FAIR_EN to bound IF starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              arb_busy
);

  arb_state_t        state_reg, state_next;
  arb_owner_t        winner;
  logic              force_if;

  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
  logic [DATA_W-1:0] dm_rdata_reg, dm_rdata_next;
  logic              if_gnt_reg, if_gnt_next;
  logic              dm_gnt_reg, dm_gnt_next;
  logic              busy_reg, busy_next;

`ifdef ARB_FAIR_EN
  logic streak_inc, streak_clr, streak_at_max;

  // A data grant counts as contested when IF is still waiting in the grant cycle.
  assign streak_inc = (state_reg == ARB_RESP_D) && if_req;
  assign streak_clr = (state_reg == ARB_RESP_I) || ((state_reg == ARB_IDLE) && !if_req);

  mem_arb_streak_ctr #(
    .MAX(STREAK_MAX)
  ) u_streak (
    .clk    (clk),
    .reset  (reset),
    .inc    (streak_inc),
    .clr    (streak_clr),
    .at_max (streak_at_max)
  );

  assign force_if = streak_at_max;
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ARB_IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
      if_gnt_reg    <= 1'b0;
      dm_gnt_reg    <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
      if_gnt_reg    <= if_gnt_next;
      dm_gnt_reg    <= dm_gnt_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    winner         = OWN_DM;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    if_gnt_next    = 1'b0;
    dm_gnt_next    = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (dm_req || if_req) begin
          winner = (dm_req && !(if_req && force_if)) ? OWN_DM : OWN_IF;
          mem_req_next = 1'b1;
          if (winner == OWN_DM) begin
            state_next     = ARB_BUSY_D;
            mem_we_next    = dm_we;
            mem_addr_next  = dm_addr;
            mem_wdata_next = dm_wdata;
          end else begin
            state_next     = ARB_BUSY_I;
            mem_we_next    = 1'b0;
            mem_addr_next  = if_addr;
            mem_wdata_next = '0;
          end
        end
      end
      ARB_BUSY_I: begin
        if (mem_ack) begin
          state_next     = ARB_RESP_I;
          if_rdata_next  = mem_rdata;
          if_gnt_next    = 1'b1;
          mem_req_next   = 1'b0;
          mem_we_next    = 1'b0;
          mem_addr_next  = '0;
          mem_wdata_next = '0;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ack) begin
          state_next     = ARB_RESP_D;
          if (!mem_we_reg) begin
            dm_rdata_next = mem_rdata;
          end
          dm_gnt_next    = 1'b1;
          mem_req_next   = 1'b0;
          mem_we_next    = 1'b0;
          mem_addr_next  = '0;
          mem_wdata_next = '0;
        end
      end
      // Grant cycle: no arbitration here, so a still-held request waits for IDLE.
      ARB_RESP_I, ARB_RESP_D: state_next = ARB_IDLE;
      default:                state_next = ARB_IDLE;
    endcase

    busy_next = (state_next != ARB_IDLE);
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign dm_rdata  = dm_rdata_reg;
  assign if_gnt    = if_gnt_reg;
  assign dm_gnt    = dm_gnt_reg;
  assign arb_busy  = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a transaction-level
// model of the priority/fairness rules; honours ARB_FAIR_EN when defined.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;
`ifdef ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        arb_busy;

  int total = 0;
  int bad   = 0;

  // Model state: expected read-data registers, fairness streak, IF grant tally.
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_dm_rdata;
  int          streak;
  int          if_gnt_seen;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STREAK_MAX(SMAX)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_busy(arb_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_if_gnt"}, 64'(if_gnt), 64'(0));
    check({tag, "_dm_gnt"}, 64'(dm_gnt), 64'(0));
    check({tag, "_mem_req"}, 64'(mem_req), 64'(0));
    check({tag, "_busy"}, 64'(arb_busy), 64'(0));
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'(exp_if_rdata));
    check({tag, "_dm_rdata"}, 64'(dm_rdata), 64'(exp_dm_rdata));
  endtask

  // One full transaction starting from IDLE with requests already applied.
  task automatic run_txn(input string tag, input int lat, input logic [31:0] rd,
                         input bit keep, input bit drop_early);
    bit          to_dm;
    logic [31:0] ea, ew;
    logic        ewe;
    if (!if_req) streak = 0;
    to_dm = dm_req && !(if_req && FAIR && (streak == SMAX));
    ea    = to_dm ? dm_addr : if_addr;
    ewe   = to_dm ? dm_we : 1'b0;
    ew    = to_dm ? dm_wdata : 32'h0;
    tick();
    for (int c = 1; c <= lat; c++) begin
      check({tag, "_mem_req"}, 64'(mem_req), 64'(1));
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'(ea));
      check({tag, "_mem_we"}, 64'(mem_we), 64'(ewe));
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(ew));
      check({tag, "_gnt_early"}, 64'({if_gnt, dm_gnt}), 64'(0));
      if (drop_early && c == 1) begin
        if (to_dm) dm_req = 1'b0; else if_req = 1'b0;
      end
      if (c < lat) tick();
    end
    mem_ack   = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (to_dm) begin
      if (!ewe) exp_dm_rdata = rd;
      if (if_req) streak = (streak < SMAX) ? streak + 1 : SMAX;
    end else begin
      exp_if_rdata = rd;
      streak = 0;
    end
    if (if_gnt === 1'b1) if_gnt_seen++;
    check({tag, "_if_gnt"}, 64'(if_gnt), 64'(!to_dm));
    check({tag, "_dm_gnt"}, 64'(dm_gnt), 64'(to_dm));
    check({tag, "_if_rdata"}, 64'(if_rdata), 64'(exp_if_rdata));
    check({tag, "_dm_rdata"}, 64'(dm_rdata), 64'(exp_dm_rdata));
    check({tag, "_mem_req_clr"}, 64'(mem_req), 64'(0));
    check({tag, "_busy_resp"}, 64'(arb_busy), 64'(1));
    if (!keep) begin
      if (to_dm) dm_req = 1'b0; else if_req = 1'b0;
    end
    tick();
    check({tag, "_idle_busy"}, 64'(arb_busy), 64'(0));
    check({tag, "_idle_gnt"}, 64'({if_gnt, dm_gnt}), 64'(0));
    $display("txn %s lat=%0d winner=%s addr=%h we=%0d rd=%h", tag, lat,
             to_dm ? "DM" : "IF", ea, ewe, rd);
  endtask

  initial begin
    reset = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0; mem_ack = 0;
    exp_if_rdata = 0; exp_dm_rdata = 0; streak = 0; if_gnt_seen = 0;

    // Reset state
    tick(); tick();
    check_quiet_outputs("reset_hold");
    check("reset_mem_addr", 64'(mem_addr), 64'(0));
    reset = 1'b0;
    tick();
    check_quiet_outputs("reset_rel");

    // IF fetch, ack in cycle 1
    if_req = 1'b1; if_addr = 32'h10;
    run_txn("if_fetch", 1, 32'h0050_0093, 0, 0);

    // Contention: data load first, then IF
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
    run_txn("contend_dm", 2, 32'hA5A5_0001, 0, 0);
    run_txn("contend_if", 1, 32'hA5A5_0002, 0, 0);

    // Store with ack after 3 cycles; dm_rdata must keep the earlier load value
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h44; dm_wdata = 32'hDEAD_BEEF;
    run_txn("store", 3, 32'hFFFF_FFFF, 0, 0);

    // Requester drops req mid-transaction; grant still pulses
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    run_txn("drop_early", 2, 32'hCAFE_0001, 0, 1);

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    mem_ack = 1'b0;
    tick();
    check_quiet_outputs("stray_ack");

    // Starvation: both requests held for 20 transactions
    if_gnt_seen = 0;
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    for (int t = 0; t < 20; t++) run_txn("starve", 1 + (t % 2), $urandom, 1, 0);
    check("starve_if_grants", 64'(if_gnt_seen), FAIR ? 64'(4) : 64'(0));
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    streak = 0;

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      if (!dm_req && ($urandom % 2 == 1)) begin
        dm_req = 1'b1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
      end
      if (!if_req && ($urandom % 2 == 1)) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!dm_req && !if_req) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      run_txn("rand", $urandom_range(1, 4), $urandom, 0, ($urandom % 6) == 0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Reset during BUSY_D: mem_req drops asynchronously, later ack ignored
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400;
    tick();
    check("rst_busy_mem_req", 64'(mem_req), 64'(1));
    #3 reset = 1'b1;
    #1;
    check("rst_async_mem_req", 64'(mem_req), 64'(0));
    check("rst_async_busy", 64'(arb_busy), 64'(0));
    dm_req = 1'b0;
    exp_if_rdata = 0; exp_dm_rdata = 0; streak = 0;
    tick();
    reset = 1'b0;
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    mem_ack = 1'b0;
    check_quiet_outputs("rst_late_ack");
    tick();
    check_quiet_outputs("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences a single-ported unified memory shared by the pipeline's instruction-fetch port and data-memory port. Each requester issues a request and waits for a grant pulse. The block arbitrates, drives one memory transaction at a time, waits a variable number of cycles for the memory acknowledge, and returns registered read data. It sits between the IF/MEM stages and the memory; the pipeline stalls on any outstanding request not yet granted.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- STREAK_MAX, 4, max consecutive contested data grants before IF is forced (used only with fairness)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_gnt  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  registered fetch data
- dm_req  in  1  data request; held until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse, access complete
- dm_rdata  out  DATA_W  registered load data
- mem_req  out  1  memory transaction active; held until mem_ack
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address, passed unmodified
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- arb_busy  out  1  state is not IDLE

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- **IDLE:** arbitration happens here and only here.
  - dm_req wins over if_req, unless forced by fairness (see Configuration).
  - With no request pending, the state stays IDLE.
- **Winner selected:** next state is BUSY_x. The mem_req, mem_we, mem_addr and mem_wdata registers are loaded from the winner. For IF, mem_we = 0 and mem_wdata = 0.
- **BUSY_x:** mem_* are held constant.
  - On mem_ack, the next state is RESP_x.
  - For IF and for data loads, mem_rdata is captured into x_rdata.
  - On mem_ack, mem_req, mem_we, mem_addr and mem_wdata all clear to 0.
- **RESP_x:** x_gnt = 1 for exactly this cycle; the next state is IDLE unconditionally.
  - Arbitration is blocked in RESP_x, so a requester still holding req in its grant cycle is not re-served.
- **Stores:** dm_rdata is unchanged.
- **Ignored inputs:**
  - mem_ack is ignored in IDLE and RESP_x.
  - A requester dropping req while in BUSY_x does not abort the transaction; gnt still pulses.
- **Reset values:** every output and register resets to 0; the state resets to IDLE; the streak counter resets to 0.
- **Reset during BUSY:** the transaction is abandoned. mem_req drops asynchronously, no gnt is issued, and a later mem_ack is ignored.

## Timing
- Request sampled in IDLE at cycle 0, then:
  - mem_req = 1 from cycle 1;
  - mem_ack at cycle k ≥ 1;
  - gnt and rdata valid at cycle k+1;
  - IDLE at cycle k+2.
- Minimum req-to-gnt is 2 cycles; peak throughput is one access per 3 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- ARB_FAIR_EN defined:
  - A streak counter increments on each data grant issued while if_req was also high.
  - It clears on any IF grant, and in any IDLE cycle where if_req = 0.
  - When the counter equals STREAK_MAX and both requests are present, IF wins.
  - The counter saturates at STREAK_MAX.
- ARB_FAIR_EN undefined:
  - Strict data priority; the counter logic is absent.
  - IF can starve indefinitely.

## Structure
- Package mem_arb_pkg holds:
  - the state enum typedef (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D, ARB_RESP_I, ARB_RESP_D);
  - the owner encoding constants OWN_IF and OWN_DM.
- Sub-module mem_arb_streak_ctr holds the saturating fairness counter. It is instantiated only under ARB_FAIR_EN.

## Test plan
- **IF fetch:** if_req=1, if_addr=0x10, mem_ack in cycle 1 with mem_rdata=0x00500093 → mem_addr=0x10 and mem_we=0 in cycle 1; if_gnt=1 and if_rdata=0x00500093 in cycle 2; IDLE in cycle 3.
- **Contention:** if_req and dm_req rise together, dm_we=0, dm_addr=0x40 → mem_addr=0x40 first; dm_gnt first; IF is then served with mem_addr=if_addr.
- **Store:** dm_we=1, dm_addr=0x44, dm_wdata=0xDEADBEEF, mem_ack after 3 cycles → mem_we=1 and mem_wdata=0xDEADBEEF are held 3 cycles; dm_gnt pulses once; dm_rdata is unchanged.
- **Starvation:** dm_req and if_req held high for 20 transactions, STREAK_MAX=4 → with ARB_FAIR_EN, every 5th grant is if_gnt; without it, if_gnt never asserts.
- **Reset mid-transaction:** reset during BUSY_D with mem_req=1 → mem_req=0 immediately; a mem_ack 2 cycles after reset release produces no gnt; state stays IDLE.
- **Stray ack:** mem_ack pulsed in IDLE with no requests → no gnt; rdata registers unchanged.
